if_pc_fetch: RTL and testbench
==============================

Name: if_pc_fetch

Overview:
- Fetch-stage PC generator and fetch queue. It sits directly upstream of the IF/ID branch-target adder, which produces offset_pc.
- Holds the architectural fetch PC and issues in-order requests to instruction memory over a valid/ready handshake.
- Buffers returned instructions with their PCs for the IF/ID register.
- Accepts redirects (the branch target, offset_pc) and squashes wrong-path responses still in flight.

Parameters:
- ADDR_W, INST_MEMORY_ADDRESS_WIDTH: PC and memory address width.
- DATA_W, RISC_V_DATA_WIDTH: instruction word width.
- RESET_PC, 0: PC value loaded at reset.
- FQ_DEPTH, 2: fetch-queue entries; also the credit limit on outstanding requests (power of two, at least 2).

Ports:
- clk  in  1  clock, all state on posedge.
- rst_n  in  1  asynchronous active-low reset.
- redirect_valid  in  1  load redirect_pc this cycle (taken branch/jump).
- redirect_pc  in  ADDR_W  redirect target (offset_pc from the IF/ID target adder).
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  ADDR_W  fetch address.
- imem_rsp_valid  in  1  in-order response valid; always accepted, no backpressure.
- imem_rsp_data  in  DATA_W  instruction word.
- ifid_valid  out  1  queue head valid.
- ifid_ready  in  1  IF/ID accepts head (low = decode stall).
- ifid_pc  out  ADDR_W  PC of head instruction.
- ifid_inst  out  DATA_W  head instruction.
- misalign_err  out  1  sticky misaligned-redirect flag (optional feature only; tied 0 otherwise).

Behaviour:
- Reset (rst_n low, asynchronous):
  - pc=RESET_PC, outstanding=0, stale=0, queue empty, state=IDLE.
  - imem_req_valid=0, ifid_valid=0, ifid_pc=0, ifid_inst=0, misalign_err=0.
  - Assertion mid-transaction discards everything; responses arriving while rst_n is low are ignored.
- IDLE: one cycle after reset release with no request issued, then go to RUN.
- RUN:
  - imem_req_valid=1 when outstanding + occupancy < FQ_DEPTH, so every response has a guaranteed slot.
  - imem_req_addr=pc.
  - On handshake (valid & ready): pc <= pc+4 (wraps modulo 2^ADDR_W), outstanding++.
  - The request is registered. Its address is held stable while valid is high and ready is low.
- Response, non-stale (stale==0): push {pc_fifo head, imem_rsp_data} to the queue; outstanding--.
  - An internal PC FIFO, FQ_DEPTH deep, records the address of each accepted request.
- Response, stale (stale>0): discard the word, stale--, outstanding--, pop the PC FIFO.
- Queue:
  - ifid_* reflects the head combinationally from registers.
  - Pop on ifid_valid & ifid_ready.
  - Simultaneous push and pop is allowed at any occupancy, including full.
- redirect_valid (highest priority, any state except reset):
  - pc <= redirect_pc and the fetch queue is flushed.
  - stale <= outstanding after this cycle's accounting: outstanding + req_fire − rsp_fire.
  - The request presented that same cycle is NOT counted as a redirect-path request. It is counted in stale if it fires.
  - ifid_valid=0 from the next cycle.
  - Next state = DRAIN if the new stale count is >0, else RUN.
- DRAIN:
  - No new requests (imem_req_valid=0).
  - Each response decrements stale.
  - Return to RUN the cycle after stale reaches 0.
  - A further redirect in DRAIN updates pc and keeps the stale count; it does not add entries.
- Redirect while a request is pending (valid & !ready): the request is withdrawn next cycle. The AXI-style valid-hold rule is waived on redirect only.
- Ordering: responses arrive in request order. At most FQ_DEPTH are outstanding.

Optional Feature:
- Macro IFETCH_MISALIGN_TRAP_EN.
- Defined:
  - A redirect with redirect_pc[1:0]!=0 sets misalign_err (sticky until reset).
  - State goes to HALT: no further requests; stale responses are drained and discarded.
  - The queue is flushed and ifid_valid stays 0.
- Undefined:
  - redirect_pc[1:0] is ignored and forced to 2'b00 when loaded.
  - misalign_err is tied to 0 and the HALT state is not generated.

Test Plan:
- Reset release, memory always ready, 1-cycle response, ifid_ready=1 -> requests 0x0, 0x4, 0x8 on consecutive cycles from the 2nd cycle after release; ifid_pc 0x0, 0x4, 0x8 with matching insts.
- ifid_ready=0 for 5 cycles -> exactly FQ_DEPTH=2 requests issued, then imem_req_valid=0; queue holds 0x0, 0x4; resumes from 0x8 when ready=1.
- redirect_valid with redirect_pc=0x100 while 2 requests are outstanding -> queue flushed; next 2 responses dropped; first new request addr=0x100; ifid_pc=0x100 next.
- imem_req_ready low for 3 cycles at addr 0x8 -> addr held at 0x8, no pc advance; single increment on accept.
- Redirect in the same cycle as a response and a request fire -> stale count correct; no wrong-path inst appears at ifid.
- With IFETCH_MISALIGN_TRAP_EN: redirect_pc=0x102 -> misalign_err=1 next cycle, no further requests, ifid_valid=0. Without the macro: fetch proceeds at 0x100.

Source files
------------

// File: rtl/if_pc_fetch.sv
// Fetch-stage PC generator: credit-limited in-order imem requests, fetch queue toward IF/ID,
// redirect with wrong-path squash. Define IFETCH_MISALIGN_TRAP_EN to trap misaligned redirects.
module if_pc_fetch #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                FQ_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [DATA_W-1:0] imem_rsp_data,
    output logic              ifid_valid,
    input  logic              ifid_ready,
    output logic [ADDR_W-1:0] ifid_pc,
    output logic [DATA_W-1:0] ifid_inst,
    output logic              misalign_err
);

    localparam int PTR_W = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FQ_DEPTH);

`ifdef IFETCH_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, HALT} state_t;
`else
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
`endif

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc;
    logic [CNT_W-1:0]  outstanding, outstanding_nxt;
    logic [CNT_W-1:0]  stale, stale_nxt;

    logic [ADDR_W-1:0] pf_addr [FQ_DEPTH];
    logic [PTR_W-1:0]  pf_wr, pf_rd;

    logic [ADDR_W-1:0] fq_pc   [FQ_DEPTH];
    logic [DATA_W-1:0] fq_inst [FQ_DEPTH];
    logic [PTR_W-1:0]  fq_wr, fq_rd;
    logic [CNT_W-1:0]  fq_count;

    logic              req_fire, rsp_fire, push, pop;
    logic [ADDR_W-1:0] redir_target;

    // A request is only offered when a queue slot is reserved for its response.
    assign imem_req_valid = (state == RUN) &&
                            (({1'b0, outstanding} + {1'b0, fq_count}) < DEPTH_C);
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign rsp_fire       = imem_rsp_valid && (outstanding != '0);
    assign push           = rsp_fire && (stale == '0) && !redirect_valid;

    assign ifid_valid = (fq_count != '0);
    assign pop        = ifid_valid && ifid_ready;
    assign ifid_pc    = ifid_valid ? fq_pc[fq_rd]   : '0;
    assign ifid_inst  = ifid_valid ? fq_inst[fq_rd] : '0;

`ifdef IFETCH_MISALIGN_TRAP_EN
    logic redir_bad;
    assign redir_bad    = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign redir_target = redirect_pc;
`else
    assign redir_target = redirect_pc & ~ADDR_W'(3);
`endif

    always_comb begin
        outstanding_nxt = outstanding + CNT_W'(req_fire) - CNT_W'(rsp_fire);
        stale_nxt       = stale;
        state_nxt       = state;
        // Everything still in flight after a redirect, including a request firing now, is wrong-path.
        if (redirect_valid) begin
            stale_nxt = outstanding_nxt;
        end else if (rsp_fire && (stale != '0)) begin
            stale_nxt = stale - CNT_W'(1);
        end
        case (state)
            IDLE:    state_nxt = RUN;
            DRAIN:   if (stale_nxt == '0) state_nxt = RUN;
            default: state_nxt = state;
        endcase
        if (redirect_valid) begin
            state_nxt = (stale_nxt != '0) ? DRAIN : RUN;
`ifdef IFETCH_MISALIGN_TRAP_EN
            if (redir_bad || (state == HALT)) state_nxt = HALT;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            outstanding <= '0;
            stale       <= '0;
        end else begin
            state       <= state_nxt;
            outstanding <= outstanding_nxt;
            stale       <= stale_nxt;
            if (redirect_valid) begin
                pc <= redir_target;
            end else if (req_fire) begin
                pc <= pc + ADDR_W'(4);
            end
        end
    end

    // The PC FIFO tracks every accepted request, so it is never flushed; stale responses pop it too.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pf_wr <= '0;
            pf_rd <= '0;
        end else begin
            if (req_fire) pf_wr <= pf_wr + PTR_W'(1);
            if (rsp_fire) pf_rd <= pf_rd + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire) pf_addr[pf_wr] <= pc;
        if (push) begin
            fq_pc[fq_wr]   <= pf_addr[pf_rd];
            fq_inst[fq_wr] <= imem_rsp_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fq_wr    <= '0;
            fq_rd    <= '0;
            fq_count <= '0;
        end else if (redirect_valid) begin
            fq_wr    <= '0;
            fq_rd    <= '0;
            fq_count <= '0;
        end else begin
            if (push) fq_wr <= fq_wr + PTR_W'(1);
            if (pop)  fq_rd <= fq_rd + PTR_W'(1);
            fq_count <= fq_count + CNT_W'(push) - CNT_W'(pop);
        end
    end

`ifdef IFETCH_MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_err <= 1'b0;
        end else if (redir_bad) begin
            misalign_err <= 1'b1;
        end
    end
`else
    assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_if_pc_fetch.sv
// Bench for if_pc_fetch: in-order memory model with random latency and a queue-based reference
// of fetch order, wrong-path squashing and request credit.
module tb_if_pc_fetch;

    localparam int FQ_DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        ifid_valid;
    logic        ifid_ready = 1'b0;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_inst;
    logic        misalign_err;

    if_pc_fetch #(
        .ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0), .FQ_DEPTH(FQ_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .ifid_valid(ifid_valid), .ifid_ready(ifid_ready),
        .ifid_pc(ifid_pc), .ifid_inst(ifid_inst),
        .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        bit          wrong;
        int          cyc;
    } req_t;

    req_t        inflight[$];
    logic [31:0] held[$];
    logic [31:0] fetch_pc;
    bit          halted, exp_misalign;
    int          cyc, checks, failures;
    int          ready_pct, rsp_pct, ifid_pct, redir_pct;
    bit          force_redir, sync_redir, sync_hit;
    logic [31:0] force_target;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
    endfunction

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic set_knobs(input int rdy, input int rsp, input int ifr, input int rdr);
        ready_pct = rdy;
        rsp_pct   = rsp;
        ifid_pct  = ifr;
        redir_pct = rdr;
    endtask

    // Holds reset over a few edges (with a response driven that must be ignored), then releases it.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_output("rst_req_valid", imem_req_valid, 0);
        check_output("rst_ifid_valid", ifid_valid, 0);
        check_output("rst_ifid_pc", ifid_pc, 0);
        check_output("rst_ifid_inst", ifid_inst, 0);
        check_output("rst_misalign", misalign_err, 0);
        inflight.delete();
        held.delete();
        fetch_pc       = 32'h0;
        halted         = 1'b0;
        exp_misalign   = 1'b0;
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        ifid_ready     = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        repeat (3) @(posedge clk);
        #1;
        imem_rsp_valid = 1'b0;
        rst_n          = 1'b1;
        #2;
        check_output("idle_req_valid", imem_req_valid, 0);
        check_output("idle_ifid_valid", ifid_valid, 0);
        cyc = 0;
    endtask

    // One clock: drive inputs after the edge, compare against the reference, then advance it.
    task automatic apply_stimulus();
        bit   exp_valid, wrong_pending, req_fire, pop;
        req_t r;
        @(posedge clk);
        #1;
        cyc++;
        imem_req_ready = ($urandom_range(99) < ready_pct);
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
        if (inflight.size() > 0 && inflight[0].cyc < cyc && $urandom_range(99) < rsp_pct) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = inst_of(inflight[0].addr);
        end
        ifid_ready     = ($urandom_range(99) < ifid_pct);
        redirect_valid = 1'b0;
        redirect_pc    = $urandom & 32'hFFFF_FFFC;
        if (force_redir) begin
            redirect_valid = 1'b1;
            redirect_pc    = force_target;
        end else if (sync_redir) begin
            if (imem_rsp_valid && imem_req_valid && imem_req_ready) begin
                redirect_valid = 1'b1;
                sync_hit       = 1'b1;
            end
        end else if ($urandom_range(99) < redir_pct) begin
            redirect_valid = 1'b1;
        end
        #3;
        wrong_pending = 1'b0;
        foreach (inflight[i]) if (inflight[i].wrong) wrong_pending = 1'b1;
        exp_valid = !halted && !wrong_pending && (inflight.size() + held.size() < FQ_DEPTH);
        check_output("req_valid", imem_req_valid, exp_valid);
        if (exp_valid) check_output("req_addr", imem_req_addr, fetch_pc);
        check_output("ifid_valid", ifid_valid, held.size() != 0);
        if (held.size() != 0) begin
            check_output("ifid_pc", ifid_pc, held[0]);
            check_output("ifid_inst", ifid_inst, inst_of(held[0]));
        end
        check_output("misalign_err", misalign_err, exp_misalign);

        req_fire = imem_req_valid && imem_req_ready;
        pop      = ifid_valid && ifid_ready && (held.size() != 0);
        if (pop && !redirect_valid) void'(held.pop_front());
        if (imem_rsp_valid) begin
            r = inflight.pop_front();
            if (!r.wrong && !redirect_valid && !halted) held.push_back(r.addr);
        end
        if (req_fire) begin
            inflight.push_back('{imem_req_addr, redirect_valid, cyc});
            fetch_pc = fetch_pc + 32'd4;
        end
        if (redirect_valid) begin
            foreach (inflight[i]) inflight[i].wrong = 1'b1;
            held.delete();
`ifdef IFETCH_MISALIGN_TRAP_EN
            fetch_pc = redirect_pc;
            if (redirect_pc[1:0] != 2'b00) begin
                halted       = 1'b1;
                exp_misalign = 1'b1;
            end
`else
            fetch_pc = redirect_pc & 32'hFFFF_FFFC;
`endif
        end
    endtask

    initial begin
        int n;
        checks = 0;
        failures = 0;
        force_redir = 1'b0;
        sync_redir = 1'b0;
        sync_hit = 1'b0;
        force_target = '0;

        // Streaming with an always-ready memory and 1-cycle responses.
        do_reset();
        set_knobs(100, 100, 100, 0);
        repeat (12) apply_stimulus();

        // Decode stall: credit caps the fetch at two, then resumes.
        do_reset();
        set_knobs(100, 100, 0, 0);
        repeat (6) apply_stimulus();
        check_output("stall_req_valid", imem_req_valid, 0);
        check_output("stall_head_pc", ifid_pc, 32'h0);
        set_knobs(100, 100, 100, 0);
        repeat (8) apply_stimulus();

        // Redirect to 0x100 with two requests outstanding.
        do_reset();
        set_knobs(100, 0, 100, 0);
        repeat (3) apply_stimulus();
        force_redir  = 1'b1;
        force_target = 32'h100;
        apply_stimulus();
        force_redir = 1'b0;
        set_knobs(100, 100, 100, 0);
        n = 0;
        do begin
            apply_stimulus();
            n++;
        end while (!imem_req_valid && n < 10);
        check_output("redir_first_addr", imem_req_addr, 32'h100);
        repeat (6) apply_stimulus();

        // Memory back-pressure holds the address at 0x8.
        do_reset();
        set_knobs(100, 100, 100, 0);
        n = 0;
        while (fetch_pc != 32'h8 && n < 10) begin
            apply_stimulus();
            n++;
        end
        set_knobs(0, 100, 100, 0);
        repeat (3) apply_stimulus();
        check_output("hold_addr", imem_req_addr, 32'h8);
        set_knobs(100, 100, 100, 0);
        repeat (4) apply_stimulus();

        // Redirect coinciding with a response and a firing request.
        sync_hit   = 1'b0;
        sync_redir = 1'b1;
        n = 0;
        while (!sync_hit && n < 20) begin
            apply_stimulus();
            n++;
        end
        sync_redir = 1'b0;
        check_output("sync_redirect_seen", sync_hit, 1);
        repeat (8) apply_stimulus();

        // PC wrap past the top of the address space.
        force_redir  = 1'b1;
        force_target = 32'hFFFF_FFF8;
        apply_stimulus();
        force_redir = 1'b0;
        repeat (10) apply_stimulus();

        // Randomized traffic.
        set_knobs(70, 50, 70, 4);
        repeat (2500) apply_stimulus();

        // Misaligned redirect target.
        set_knobs(100, 100, 100, 0);
        force_redir  = 1'b1;
        force_target = 32'h102;
        apply_stimulus();
        force_redir = 1'b0;
        apply_stimulus();
`ifdef IFETCH_MISALIGN_TRAP_EN
        check_output("misalign_set", misalign_err, 1);
`else
        check_output("misalign_clear", misalign_err, 0);
`endif
        repeat (8) apply_stimulus();

        // Asynchronous reset in the middle of traffic.
        set_knobs(80, 60, 70, 3);
        repeat (20) apply_stimulus();
        @(posedge clk);
        #3;
        do_reset();
        set_knobs(80, 60, 70, 3);
        repeat (200) apply_stimulus();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
